// File: rtl/pipe_addsub_pkg.sv
// Shared types and helpers for the segmented pipelined adder/subtractor.
// Saturation constants are built here for any operand width up to SAT_MAX_WIDTH.
package pipe_addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int SAT_MAX_WIDTH = 1024;

    function automatic int num_segs(input int data_width, input int seg_width);
        return (seg_width > 0) ? data_width / seg_width : 0;
    endfunction

    // Most negative two's-complement value of the given width: 1000...0
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_neg(input int width);
        logic [SAT_MAX_WIDTH-1:0] v;
        v = '0;
        v[width-1] = 1'b1;
        return v;
    endfunction

    // Most positive two's-complement value of the given width: 0111...1
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_pos(input int width);
        return sat_neg(width) - 1'b1;
    endfunction

endpackage

// File: rtl/addsub_seg_stage.sv
// One carry segment: SEG_WIDTH-bit add of a, b and cin into a registered {cout, sum}.
// The register only moves when adv is high so the whole pipeline stalls together.
module addsub_seg_stage
    import pipe_addsub_pkg::*;
#(
    parameter int SEG_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adv,
    input  logic [SEG_WIDTH-1:0] a,
    input  logic [SEG_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [SEG_WIDTH-1:0] sum,
    output logic                 cout
);

    logic [SEG_WIDTH:0] acc_d;
    logic [SEG_WIDTH:0] acc_q;

    always_comb begin
        acc_d = {1'b0, a} + {1'b0, b} + {{SEG_WIDTH{1'b0}}, cin};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (adv) begin
            acc_q <= acc_d;
        end
    end

    assign sum  = acc_q[SEG_WIDTH-1:0];
    assign cout = acc_q[SEG_WIDTH];

endmodule

// File: rtl/pipe_addsub_seg.sv
// Segmented pipelined adder/subtractor: carry ripples one segment per cycle, latency NUM_SEGS.
// Optional signed saturation of the result when PIPE_ADDSUB_SAT_EN is defined.
module pipe_addsub_seg
    import pipe_addsub_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int SEG_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic                  i_sub,
    input  logic                  i_cin,
    input  logic [DATA_WIDTH-1:0] adda,
    input  logic [DATA_WIDTH-1:0] addb,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  o_cout,
    output logic                  o_ovf
);

    localparam int NUM_SEGS = num_segs(DATA_WIDTH, SEG_WIDTH);
    localparam int MSB      = DATA_WIDTH - 1;

    if (SEG_WIDTH < 1 || DATA_WIDTH < SEG_WIDTH || (DATA_WIDTH % SEG_WIDTH) != 0) begin : g_param_check
        $fatal(1, "pipe_addsub_seg: DATA_WIDTH must be a non-zero multiple of SEG_WIDTH");
    end

    logic                  adv;
    op_e                   op;
    logic [DATA_WIDTH-1:0] beff;
    logic                  ceff;
    logic [DATA_WIDTH-1:0] a_stage;
    logic [DATA_WIDTH-1:0] b_stage;
    logic [DATA_WIDTH-1:0] sum_q;
    logic [DATA_WIDTH-1:0] result_raw;
    logic [NUM_SEGS-1:0]   carry_q;
    logic [NUM_SEGS-1:0]   valid_d;
    logic [NUM_SEGS-1:0]   valid_q;
    logic                  a_msb_d;
    logic                  a_msb_q;
    logic                  b_msb_d;
    logic                  b_msb_q;

    assign adv     = ~valid_q[NUM_SEGS-1] | o_ready;
    assign i_ready = adv;
    assign op      = op_e'(i_sub);

    always_comb begin
        beff = (op == OP_SUB) ? ~addb : addb;
        ceff = (op == OP_SUB) ? ~i_cin : i_cin;
    end

    genvar gi;
    for (gi = 0; gi < NUM_SEGS; gi++) begin : g_seg
        localparam int LO  = gi * SEG_WIDTH;
        localparam int DSK = NUM_SEGS - 1 - gi;

        logic seg_cin;

        // Segment gi waits gi cycles so it meets the carry of its own transaction.
        if (gi == 0) begin : g_first
            assign a_stage[LO +: SEG_WIDTH] = adda[LO +: SEG_WIDTH];
            assign b_stage[LO +: SEG_WIDTH] = beff[LO +: SEG_WIDTH];
            assign seg_cin = ceff;
        end else begin : g_skew
            logic [SEG_WIDTH-1:0] a_sk_d [gi];
            logic [SEG_WIDTH-1:0] a_sk_q [gi];
            logic [SEG_WIDTH-1:0] b_sk_d [gi];
            logic [SEG_WIDTH-1:0] b_sk_q [gi];

            always_comb begin
                a_sk_d[0] = adda[LO +: SEG_WIDTH];
                b_sk_d[0] = beff[LO +: SEG_WIDTH];
                for (int j = 1; j < gi; j++) begin
                    a_sk_d[j] = a_sk_q[j-1];
                    b_sk_d[j] = b_sk_q[j-1];
                end
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    a_sk_q <= a_sk_d;
                    b_sk_q <= b_sk_d;
                end
            end

            assign a_stage[LO +: SEG_WIDTH] = a_sk_q[gi-1];
            assign b_stage[LO +: SEG_WIDTH] = b_sk_q[gi-1];
            assign seg_cin = carry_q[gi-1];
        end

        addsub_seg_stage #(
            .SEG_WIDTH(SEG_WIDTH)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .adv  (adv),
            .a    (a_stage[LO +: SEG_WIDTH]),
            .b    (b_stage[LO +: SEG_WIDTH]),
            .cin  (seg_cin),
            .sum  (sum_q[LO +: SEG_WIDTH]),
            .cout (carry_q[gi])
        );

        // Lower sums wait for the top segment so the whole word emerges at once.
        if (DSK == 0) begin : g_top
            assign result_raw[LO +: SEG_WIDTH] = sum_q[LO +: SEG_WIDTH];
        end else begin : g_deskew
            logic [SEG_WIDTH-1:0] dsk_d [DSK];
            logic [SEG_WIDTH-1:0] dsk_q [DSK];

            always_comb begin
                dsk_d[0] = sum_q[LO +: SEG_WIDTH];
                for (int j = 1; j < DSK; j++) begin
                    dsk_d[j] = dsk_q[j-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < DSK; j++) begin
                        dsk_q[j] <= '0;
                    end
                end else if (adv) begin
                    dsk_q <= dsk_d;
                end
            end

            assign result_raw[LO +: SEG_WIDTH] = dsk_q[DSK-1];
        end
    end

    always_comb begin
        valid_d[0] = i_valid;
        for (int k = 1; k < NUM_SEGS; k++) begin
            valid_d[k] = valid_q[k-1];
        end
        a_msb_d = a_stage[MSB];
        b_msb_d = b_stage[MSB];
    end

    // Operand sign bits travel alongside the top segment for overflow detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (adv) begin
            valid_q <= valid_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    assign o_valid = valid_q[NUM_SEGS-1];
    assign o_cout  = carry_q[NUM_SEGS-1];
    assign o_ovf   = (a_msb_q == b_msb_q) && (result_raw[MSB] != a_msb_q);

`ifdef PIPE_ADDSUB_SAT_EN
    localparam logic [DATA_WIDTH-1:0] SAT_POS = DATA_WIDTH'(sat_pos(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] SAT_NEG = DATA_WIDTH'(sat_neg(DATA_WIDTH));

    assign result = o_ovf ? (a_msb_q ? SAT_NEG : SAT_POS) : result_raw;
`else
    assign result = result_raw;
`endif

endmodule
